// File: rtl/sprite_motion_sched.sv
// sprite_motion_sched: per-frame sprite position sequencer.
// A frame tick is the rising edge of the synchronised vertical sync. Each tick
// walks every sprite through an X step and then a Y step on one shared adder,
// bounces off the play-field edges, and commits all positions at once.
// Optional build macro SPRITE_MOTION_PAUSE_EN adds i_pause. While i_pause is
// high at commit, the frame's updates are discarded and the pre-frame
// positions and velocities are restored.
//
// state  | meaning
// IDLE   | waiting for an enabled frame tick
// UPD_X  | X axis step for sprite idx
// UPD_Y  | Y axis step for sprite idx
// COMMIT | new positions visible on outputs, frame_done pulse
module sprite_motion_sched #(
    parameter int NUM_SPR = 4,
    parameter int MAX_X   = 200,
    parameter int MAX_Y   = 150,
    parameter int INIT_VX = 3,
    parameter int INIT_VY = 2
) (
    input  logic                   i_pix_clk,
    input  logic                   i_reset_n,
    input  logic                   i_vert_sync,
    input  logic                   i_enable,
`ifdef SPRITE_MOTION_PAUSE_EN
    input  logic                   i_pause,
`endif
    output logic [16*NUM_SPR-1:0]  o_x_coord,
    output logic [16*NUM_SPR-1:0]  o_y_coord,
    output logic                   o_busy,
    output logic                   o_frame_done,
    output logic                   o_overrun
);

    localparam int IW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SPR - 1);

    typedef enum logic [1:0] {IDLE, UPD_X, UPD_Y, COMMIT} state_t;

    state_t              state_q;
    logic [IW-1:0]       idx_q;
    logic                vs_meta_q, vs_sync_q, vs_prev_q;
    logic                busy_q, done_q, overrun_q;
    logic signed [15:0]  sx_q [NUM_SPR];
    logic signed [15:0]  sy_q [NUM_SPR];
    logic signed [15:0]  vx_q [NUM_SPR];
    logic signed [15:0]  vy_q [NUM_SPR];
    logic [16*NUM_SPR-1:0] ox_q, oy_q;
`ifdef SPRITE_MOTION_PAUSE_EN
    logic signed [15:0]  bvx_q [NUM_SPR];
    logic signed [15:0]  bvy_q [NUM_SPR];
`endif

    logic                tick;
    logic                start;
    logic                last_y;
    logic                is_x;
    logic signed [15:0]  pos_op, vel_op;
    logic signed [16:0]  sum, bound;
    logic signed [15:0]  nxt_pos_d, nxt_vel_d;

    assign tick   = vs_sync_q & ~vs_prev_q;
    assign start  = (state_q == IDLE) && tick && i_enable;
    assign last_y = (state_q == UPD_Y) && (idx_q == LAST_IDX);
    assign is_x   = (state_q == UPD_X);

    // Shared axis step: one adder, operands muxed by the current axis.
    always_comb begin
        pos_op    = is_x ? sx_q[idx_q] : sy_q[idx_q];
        vel_op    = is_x ? vx_q[idx_q] : vy_q[idx_q];
        bound     = is_x ? $signed(17'(MAX_X)) : $signed(17'(MAX_Y));
        sum       = {pos_op[15], pos_op} + {vel_op[15], vel_op};
        nxt_pos_d = sum[15:0];
        nxt_vel_d = vel_op;
        if (sum >= bound) begin
            nxt_pos_d = 16'(bound - 17'sd1);
            nxt_vel_d = -vel_op;
        end else if (sum[16]) begin
            nxt_pos_d = '0;
            nxt_vel_d = -vel_op;
        end
    end

    // Two-flop synchroniser for vsync plus the previous-value flop for edge detect.
    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vs_meta_q <= 1'b0;
            vs_sync_q <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            vs_meta_q <= i_vert_sync;
            vs_sync_q <= vs_meta_q;
            vs_prev_q <= vs_sync_q;
        end
    end

    // Sequencer FSM with registered busy/done/overrun.
    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (tick && state_q != IDLE) overrun_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= UPD_X;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                UPD_X: state_q <= UPD_Y;
                UPD_Y: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= COMMIT;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= UPD_X;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Shadow position/velocity updates and the all-at-once output commit.
    // Outputs load on entry to COMMIT so they are visible during that cycle;
    // the last sprite's Y result is taken straight from the adder.
    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < NUM_SPR; k++) begin
                sx_q[k]            <= 16'(16 * k);
                sy_q[k]            <= 16'(16 * k);
                vx_q[k]            <= 16'(INIT_VX + k);
                vy_q[k]            <= 16'(INIT_VY + k);
                ox_q[16*k +: 16]   <= 16'(16 * k);
                oy_q[16*k +: 16]   <= 16'(16 * k);
`ifdef SPRITE_MOTION_PAUSE_EN
                bvx_q[k]           <= 16'(INIT_VX + k);
                bvy_q[k]           <= 16'(INIT_VY + k);
`endif
            end
        end else begin
            if (state_q == UPD_X) begin
                sx_q[idx_q] <= nxt_pos_d;
                vx_q[idx_q] <= nxt_vel_d;
            end else if (state_q == UPD_Y) begin
                sy_q[idx_q] <= nxt_pos_d;
                vy_q[idx_q] <= nxt_vel_d;
            end
`ifdef SPRITE_MOTION_PAUSE_EN
            if (start) begin
                for (int k = 0; k < NUM_SPR; k++) begin
                    bvx_q[k] <= vx_q[k];
                    bvy_q[k] <= vy_q[k];
                end
            end
            if (last_y) begin
                if (i_pause) begin
                    // Outputs still hold the pre-frame positions; restore from them.
                    for (int k = 0; k < NUM_SPR; k++) begin
                        sx_q[k] <= ox_q[16*k +: 16];
                        sy_q[k] <= oy_q[16*k +: 16];
                        vx_q[k] <= bvx_q[k];
                        vy_q[k] <= bvy_q[k];
                    end
                end else begin
                    for (int k = 0; k < NUM_SPR; k++) begin
                        ox_q[16*k +: 16] <= sx_q[k];
                        oy_q[16*k +: 16] <= (IW'(k) == idx_q) ? nxt_pos_d : sy_q[k];
                    end
                end
            end
`else
            if (last_y) begin
                for (int k = 0; k < NUM_SPR; k++) begin
                    ox_q[16*k +: 16] <= sx_q[k];
                    oy_q[16*k +: 16] <= (IW'(k) == idx_q) ? nxt_pos_d : sy_q[k];
                end
            end
`endif
        end
    end

    assign o_x_coord    = ox_q;
    assign o_y_coord    = oy_q;
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;
    assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_sprite_motion_sched.sv
// Bench for sprite_motion_sched: frame-level reference model of sprite motion,
// randomized frame gaps and enable patterns, boundary bounces, overrun and
// mid-frame reset scenarios.
module tb_sprite_motion_sched;

    localparam int NS = 4;
    localparam int MX = 200;
    localparam int MY = 150;
    localparam int VX0 = 3;
    localparam int VY0 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vsync = 1'b0;
    logic en = 1'b1;
    logic [16*NS-1:0] xc, yc;
    logic busy, done, ovr;
`ifdef SPRITE_MOTION_PAUSE_EN
    logic pause = 1'b0;
`endif

    int nchecks = 0;
    int nerr = 0;

    int mpx[NS], mpy[NS], mvx[NS], mvy[NS];

    always #5 clk = ~clk;

    sprite_motion_sched #(
        .NUM_SPR(NS), .MAX_X(MX), .MAX_Y(MY), .INIT_VX(VX0), .INIT_VY(VY0)
    ) dut (
        .i_pix_clk    (clk),
        .i_reset_n    (rst_n),
        .i_vert_sync  (vsync),
        .i_enable     (en),
`ifdef SPRITE_MOTION_PAUSE_EN
        .i_pause      (pause),
`endif
        .o_x_coord    (xc),
        .o_y_coord    (yc),
        .o_busy       (busy),
        .o_frame_done (done),
        .o_overrun    (ovr)
    );

    function automatic int get_x(input int k);
        logic signed [15:0] v;
        v = xc[16*k +: 16];
        return int'(v);
    endfunction

    function automatic int get_y(input int k);
        logic signed [15:0] v;
        v = yc[16*k +: 16];
        return int'(v);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NS; k++) begin
            mpx[k] = 16 * k;
            mpy[k] = 16 * k;
            mvx[k] = VX0 + k;
            mvy[k] = VY0 + k;
        end
    endfunction

    // One frame of motion: step, then clamp and reflect at either edge.
    function automatic void model_frame();
        int n;
        for (int k = 0; k < NS; k++) begin
            n = mpx[k] + mvx[k];
            if (n >= MX) begin mpx[k] = MX - 1; mvx[k] = -mvx[k]; end
            else if (n < 0) begin mpx[k] = 0; mvx[k] = -mvx[k]; end
            else mpx[k] = n;
            n = mpy[k] + mvy[k];
            if (n >= MY) begin mpy[k] = MY - 1; mvy[k] = -mvy[k]; end
            else if (n < 0) begin mpy[k] = 0; mvy[k] = -mvy[k]; end
            else mpy[k] = n;
        end
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        vsync = 1'b0;
        en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    // One vsync pulse raised at a negedge; the tick is detected two cycles
    // later (E), so done is expected at the 11th negedge (E+9).
    task automatic run_frame(input bit en_start, input bit rand_drop, input string tag);
        int done_at, done_cnt, busy_bad;
        @(negedge clk);
        en = en_start;
        vsync = 1'b1;
        done_at = -1;
        done_cnt = 0;
        busy_bad = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 3) vsync = 1'b0;
            if (k == 5 && rand_drop) en = 1'($urandom_range(0, 1));
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (busy !== (en_start && k >= 3 && k <= 11)) busy_bad++;
        end
        if (en_start) model_frame();
        nchecks++;
        if (done_cnt != (en_start ? 1 : 0) || (en_start && done_at != 11)) begin
            nerr++;
            $display("FAIL %s done_timing: got count=%0d at=%0d, want count=%0d at=11", tag, done_cnt, done_at, en_start ? 1 : 0);
        end
        nchecks++;
        if (busy_bad != 0) begin
            nerr++;
            $display("FAIL %s busy_window: got %0d bad cycles, want 0", tag, busy_bad);
        end
        for (int k = 0; k < NS; k++) begin
            nchecks++;
            if (get_x(k) != mpx[k] || get_y(k) != mpy[k]) begin
                nerr++;
                $display("FAIL %s pos[%0d]: got (%0d,%0d), want (%0d,%0d)", tag, k, get_x(k), get_y(k), mpx[k], mpy[k]);
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        nchecks++;
        if (busy !== 1'b0 || done !== 1'b0 || ovr !== 1'b0) begin
            nerr++;
            $display("FAIL reset_flags: got busy=%b done=%b ovr=%b, want 0 0 0", busy, done, ovr);
        end
        nchecks++;
        if (get_x(0) != 0 || get_y(0) != 0) begin
            nerr++;
            $display("FAIL reset_spr0: got (%0d,%0d), want (0,0)", get_x(0), get_y(0));
        end
        nchecks++;
        if (get_x(3) != 48 || get_y(3) != 48) begin
            nerr++;
            $display("FAIL reset_spr3: got (%0d,%0d), want (48,48)", get_x(3), get_y(3));
        end
    endtask

    task automatic test_single_frame();
        run_frame(1'b1, 1'b0, "single");
        nchecks++;
        if (get_x(0) != 3 || get_y(0) != 2) begin
            nerr++;
            $display("FAIL single_spr0: got (%0d,%0d), want (3,2)", get_x(0), get_y(0));
        end
        nchecks++;
        if (get_x(1) != 20 || get_y(1) != 19) begin
            nerr++;
            $display("FAIL single_spr1: got (%0d,%0d), want (20,19)", get_x(1), get_y(1));
        end
        nchecks++;
        if (get_x(3) != 54 || get_y(3) != 53) begin
            nerr++;
            $display("FAIL single_spr3: got (%0d,%0d), want (54,53)", get_x(3), get_y(3));
        end
        nchecks++;
        if (ovr !== 1'b0) begin
            nerr++;
            $display("FAIL single_ovr: got %b, want 0", ovr);
        end
    endtask

    // Second vsync edge lands in cycle E+4; only one commit may happen.
    task automatic test_overrun();
        int done_at, done_cnt;
        done_at = -1;
        done_cnt = 0;
        @(negedge clk);
        en = 1'b1;
        vsync = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 1) vsync = 1'b0;
            if (k == 4) vsync = 1'b1;
            if (k == 6) vsync = 1'b0;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
        end
        model_frame();
        nchecks++;
        if (done_cnt != 1 || done_at != 11) begin
            nerr++;
            $display("FAIL overrun_done: got count=%0d at=%0d, want count=1 at=11", done_cnt, done_at);
        end
        nchecks++;
        if (ovr !== 1'b1) begin
            nerr++;
            $display("FAIL overrun_flag: got %b, want 1", ovr);
        end
        for (int k = 0; k < NS; k++) begin
            nchecks++;
            if (get_x(k) != mpx[k] || get_y(k) != mpy[k]) begin
                nerr++;
                $display("FAIL overrun_pos[%0d]: got (%0d,%0d), want (%0d,%0d)", k, get_x(k), get_y(k), mpx[k], mpy[k]);
            end
        end
        run_frame(1'b1, 1'b0, "after_overrun");
        nchecks++;
        if (ovr !== 1'b1) begin
            nerr++;
            $display("FAIL overrun_sticky: got %b, want 1", ovr);
        end
    endtask

    task automatic test_reset_midframe();
        int done_cnt, busy_cnt;
        done_cnt = 0;
        busy_cnt = 0;
        @(negedge clk);
        en = 1'b1;
        vsync = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 3) vsync = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        nchecks++;
        if (busy !== 1'b0 || done !== 1'b0 || ovr !== 1'b0) begin
            nerr++;
            $display("FAIL midreset_flags: got busy=%b done=%b ovr=%b, want 0 0 0", busy, done, ovr);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (busy === 1'b1) busy_cnt++;
        end
        nchecks++;
        if (done_cnt != 0 || busy_cnt != 0) begin
            nerr++;
            $display("FAIL midreset_quiet: got done=%0d busy=%0d cycles, want 0 0", done_cnt, busy_cnt);
        end
        for (int k = 0; k < NS; k++) begin
            nchecks++;
            if (get_x(k) != 16 * k || get_y(k) != 16 * k) begin
                nerr++;
                $display("FAIL midreset_pos[%0d]: got (%0d,%0d), want (%0d,%0d)", k, get_x(k), get_y(k), 16 * k, 16 * k);
            end
        end
    endtask

    task automatic test_enable_random();
        bit e;
        for (int f = 0; f < 16; f++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            e = 1'($urandom_range(0, 1));
            run_frame(e, 1'b1, e ? "rand_en" : "rand_dis");
        end
        nchecks++;
        if (ovr !== 1'b0) begin
            nerr++;
            $display("FAIL rand_ovr: got %b, want 0", ovr);
        end
    endtask

    task automatic test_boundaries();
        apply_reset();
        for (int f = 1; f <= 151; f++) begin
            run_frame(1'b1, 1'b0, "bound");
            if (f == 66 || f == 67 || f == 68) begin
                nchecks++;
                if (get_x(0) != ((f == 66) ? 198 : (f == 67) ? 199 : 196)) begin
                    nerr++;
                    $display("FAIL bound_x frame %0d: got %0d, want %0d", f, get_x(0), (f == 66) ? 198 : (f == 67) ? 199 : 196);
                end
            end
            if (f == 149 || f == 150 || f == 151) begin
                nchecks++;
                if (get_y(0) != ((f == 149) ? 1 : (f == 150) ? 0 : 2)) begin
                    nerr++;
                    $display("FAIL bound_y frame %0d: got %0d, want %0d", f, get_y(0), (f == 149) ? 1 : (f == 150) ? 0 : 2);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_frame();
        test_overrun();
        test_reset_midframe();
        test_enable_random();
        test_boundaries();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/sprite_motion_sched.md
SPRITE_MOTION_SCHED -- requirements
Module: sprite_motion_sched

Interface
REQ-001 SHALL have parameter NUM_SPR, default 4, number of sprites sequenced (1..8).
REQ-002 SHALL have parameter MAX_X, default 200, exclusive horizontal bound in sprite-grid units.
REQ-003 SHALL have parameter MAX_Y, default 150, exclusive vertical bound in sprite-grid units.
REQ-004 SHALL have parameter INIT_VX, default 3, base signed X velocity.
REQ-005 SHALL have parameter INIT_VY, default 2, base signed Y velocity.
REQ-006 SHALL have port i_pix_clk  input  1  single clock for all state.
REQ-007 SHALL have port i_reset_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port i_vert_sync  input  1  VGA vertical sync (async to block); rising edge = frame tick.
REQ-009 SHALL have port i_enable  input  1  when low, frame ticks do not start updates.
REQ-010 SHALL have port o_x_coord  output  16*NUM_SPR  packed signed X positions, sprite k at bits [16k+15:16k].
REQ-011 SHALL have port o_y_coord  output  16*NUM_SPR  packed signed Y positions, same packing.
REQ-012 SHALL have port o_busy  output  1  high while an update sequence runs.
REQ-013 SHALL have port o_frame_done  output  1  one-cycle pulse when new positions commit.
REQ-014 SHALL have port o_overrun  output  1  sticky flag: a frame tick arrived while busy.

Function
REQ-015 SHALL synchronise i_vert_sync through two flops and detect a rising edge (sync=1, previous=0) in cycle E.
REQ-016 SHALL use FSM states IDLE, UPD_X, UPD_Y, COMMIT; IDLE->UPD_X at E+1 when i_enable=1.
REQ-017 SHALL process sprite index 0..NUM_SPR-1 in order, UPD_X then UPD_Y per sprite, one axis per cycle via a single shared 17-bit signed adder.
REQ-018 SHALL go UPD_Y->UPD_X (next index) or, after last index, UPD_Y->COMMIT; COMMIT->IDLE after one cycle.
REQ-019 SHALL compute next = pos + vel per axis into shadow registers; outputs unchanged until COMMIT.
REQ-020 SHALL, if next >= MAX (axis bound): vel <= -vel, pos <= MAX-1.
REQ-021 SHALL, if next < 0: vel <= -vel, pos <= 0; otherwise pos <= next, vel unchanged.
REQ-022 SHALL copy all shadow positions to o_x_coord/o_y_coord in cycle E+2*NUM_SPR+1 and pulse o_frame_done high in that same cycle only.
REQ-023 SHALL hold o_busy high from E+1 through COMMIT inclusive.
REQ-024 SHALL ignore a frame-tick edge detected while not IDLE and set o_overrun=1 until reset.
REQ-025 SHALL ignore a frame tick with i_enable=0 without setting o_overrun; i_enable falling mid-sequence SHALL NOT abort the sequence.

Reset
REQ-026 SHALL on i_reset_n=0 immediately force: state IDLE, index 0, o_busy=0, o_frame_done=0, o_overrun=0, sync flops 0.
REQ-027 SHALL reset sprite k to pos (16k, 16k), vel (INIT_VX+k, INIT_VY+k), both shadow and output registers.
REQ-028 SHALL discard any partial sequence on reset; no commit occurs.

Configuration
REQ-029 SHALL, when SPRITE_MOTION_PAUSE_EN is defined, add port i_pause (input, 1): while high, COMMIT leaves shadow positions/velocities unchanged (reverted to pre-frame values), o_frame_done still pulses.
REQ-030 SHALL, without SPRITE_MOTION_PAUSE_EN, have no i_pause port and always commit updated values.

Verification (NUM_SPR=4, MAX_X=200, MAX_Y=150, INIT_VX=3, INIT_VY=2)
REQ-031 Reset release -> sprite0 (0,0), sprite3 (48,48), busy=0, done=0, overrun=0.
REQ-032 One vsync rising edge, enable=1 -> done pulse exactly 9 cycles after E; sprite0 (3,2), sprite1 (20,19), sprite3 (54,53).
REQ-033 Sprite0 x=198, vx=3, vsync -> x=199, vx=-3; next vsync -> x=196.
REQ-034 Sprite0 y=1, vy=-2, vsync -> y=0, vy=+2; next vsync -> y=2.
REQ-035 Second vsync edge at E+4 -> ignored, single commit at E+9, overrun=1 persists until reset.
REQ-036 Reset asserted at E+5 -> all outputs back to reset values, no done pulse, busy=0 immediately.
